instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the instruction decode path: takes field-level instruction requests (class, ALUControl code, data size, register indices, extended immediate) and emits RV32I 32-bit instruction words.
- Feeds the instruction-memory loader and self-test sequencer through a valid/ready stream.
- Contains a one-stage registered encoder, a skid buffer, legality checking, and encode/error counters.

Parameters:
- CNT_W, 16, width of enc_count and err_count.
- NOP_INSTR, 32'h0000_0013, word emitted in place of an illegal request.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_class  in  4  instr_class_t: OPIMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE.
- in_alu_op  in  4  ALUControl code, same encoding as the decoder.
- in_data_size  in  3  funct3 for LOAD/STORE.
- in_rs1, in_rs2, in_rd  in  5 each  register indices.
- in_imm  in  32  immediate, already extended; decoder format.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accept.
- out_instr  out  32  encoded word.
- out_err  out  1  word is NOP_INSTR substituted for an illegal request.
- enc_count  out  CNT_W  accepted requests, wraps.
- err_count  out  CNT_W  illegal requests, saturates at all-ones.
- cnt_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_err=0, in_ready=1, both counters 0, skid empty.
- Latency: an accepted request appears on out_instr in the next cycle when the output register is free. Throughput is 1 per cycle.
- Buffering: output register plus one skid register.
  - in_ready = !skid_valid, registered.
  - Input accepted while out_valid&&!out_ready goes to the skid register.
  - On the next out handshake, skid contents move to the output register.
  - With out_ready held low, exactly 2 requests are accepted, then in_ready=0.
- Stability: out_instr and out_err are held stable while out_valid&&!out_ready.
- Encoding follows the decoder map:
  - OPIMM: funct3 from alu_op; 0000→000, 1000→010, 1001→011, 0100→100, 0011→110, 0010→111, 0101→001, 0110→101 with f7=0, 0111→101 with f7=0100000.
  - OP: same funct3 map, plus 0001→000 with f7=0100000.
  - BRANCH: 1010 BEQ, 1011 BNE, 1000 BLT, 1100 BGE, 1001 BLTU, 1101 BGEU.
  - LUI requires alu_op 1111. AUIPC requires 0000. JAL/JALR require 1110.
  - LOAD/STORE use in_data_size as funct3.
- Legality; any violation substitutes NOP_INSTR with out_err=1:
  - alu_op not in the map for the class.
  - in_class undefined.
  - I-type/JALR/LOAD/STORE imm not a 12-bit sign extension.
  - Shift imm[31:5]≠0.
  - LUI/AUIPC imm[11:0]≠0.
  - BRANCH imm not 13-bit signed, or imm[0]=1.
  - JAL imm not 21-bit signed, or imm[0]=1.
  - LOAD data_size ∉ {000,001,010,100,101}; STORE data_size ∉ {000,001,010}.
- Counters:
  - enc_count increments on every input handshake, legal or not, and wraps.
  - err_count increments on illegal accepts.
  - If cnt_clr and an accept occur in the same cycle, the count becomes 0 (clear wins).
- Reset mid-operation drops all buffered words; there is no partial output.

Optional Feature:
- Macro: INSTR_ENCODER_LOADSTORE_EN.
- Defined: LOAD (0000011) and STORE (0100011) are encoded as described above.
- Undefined: LOAD/STORE classes are illegal (NOP_INSTR, out_err=1, err_count++), and the data_size legality logic is removed.

Decomposition:
- riscv_pkg additions:
  - instr_class_t enum.
  - alu_ctrl_t localparams for the 16 ALUControl codes, shared with the decoder.
  - Opcode/funct3/funct7 constants, which already exist.
- Sub-module instr_field_pack: combinational, class+fields→{word, illegal}. Instantiated once ahead of the pipeline register.

Test Plan:
- OPIMM alu 0000, rd=1, rs1=0, imm=5 → 0x00500093, out_err=0, enc_count=1.
- OP alu 0001, rd=3, rs1=1, rs2=2 → 0x402081B3.
- LUI alu 1111, rd=5, imm=0x12345000 → 0x123452B7; BRANCH alu 1010, rs1=1, rs2=2, imm=0xFFFFFFFC → 0xFE208EE3.
- JAL alu 1110, rd=0, imm=8 → 0x0080006F; OPIMM imm=4096 → 0x00000013, out_err=1, err_count=1.
- out_ready=0, 3 back-to-back requests → 2 accepted, in_ready=0. Release → words drain in order, third accepted.
- Macro undefined, LOAD request → NOP_INSTR, out_err=1. rst_n pulse while buffer full → out_valid=0, counters 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I shared types, ALUControl codes and opcode/funct constants.
// Shared between the instruction decoder and the instruction encoder.
package riscv_pkg;

   typedef enum logic [3:0] {
      CLS_OPIMM  = 4'd0,
      CLS_LUI    = 4'd1,
      CLS_AUIPC  = 4'd2,
      CLS_OP     = 4'd3,
      CLS_JAL    = 4'd4,
      CLS_JALR   = 4'd5,
      CLS_BRANCH = 4'd6,
      CLS_LOAD   = 4'd7,
      CLS_STORE  = 4'd8
   } instr_class_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_BEQ  = 4'b1010;
   localparam logic [3:0] ALU_BNE  = 4'b1011;
   localparam logic [3:0] ALU_BGE  = 4'b1100;
   localparam logic [3:0] ALU_BGEU = 4'b1101;
   localparam logic [3:0] ALU_JUMP = 4'b1110;
   localparam logic [3:0] ALU_LUI  = 4'b1111;

   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // {valid, funct3} for the ALU ops shared by OP and OP-IMM (SUB is OP-only).
   function automatic logic [3:0] alu_funct3(input logic [3:0] op);
      logic [3:0] r;
      r = 4'b0000;
      case (op)
         ALU_ADD:  r = 4'b1_000;
         ALU_SLT:  r = 4'b1_010;
         ALU_SLTU: r = 4'b1_011;
         ALU_XOR:  r = 4'b1_100;
         ALU_OR:   r = 4'b1_110;
         ALU_AND:  r = 4'b1_111;
         ALU_SLL:  r = 4'b1_001;
         ALU_SRL:  r = 4'b1_101;
         ALU_SRA:  r = 4'b1_101;
         default:  r = 4'b0_000;
      endcase
      return r;
   endfunction

   // True when v is the sign extension of its low 'bits' bits.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] hi;
      hi = $unsigned($signed(v) >>> (bits - 1));
      return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational class+fields to RV32I word with legality flag.
// LOAD/STORE encoding is present only when INSTR_ENCODER_LOADSTORE_EN is defined.
module instr_field_pack
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic [3:0]  cls,
   input  logic [3:0]  alu_op,
   input  logic [2:0]  data_size,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   instr_class_t cls_e;
   logic [3:0]   f3m;
   logic [2:0]   br_f3;
   logic         br_ok;
   logic         is_shift;
   logic [6:0]   f7;
   logic [31:0]  raw;
   logic         bad;

   assign cls_e = instr_class_t'(cls);

`ifndef INSTR_ENCODER_LOADSTORE_EN
   logic unused_size;
   assign unused_size = ^data_size;
`endif

   always_comb begin
      f3m      = alu_funct3(alu_op);
      is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
      f7       = (alu_op == ALU_SRA) ? F7_ALT : F7_BASE;
      br_ok    = 1'b1;
      br_f3    = 3'b000;
      case (alu_op)
         ALU_BEQ:  br_f3 = 3'b000;
         ALU_BNE:  br_f3 = 3'b001;
         ALU_SLT:  br_f3 = 3'b100;
         ALU_BGE:  br_f3 = 3'b101;
         ALU_SLTU: br_f3 = 3'b110;
         ALU_BGEU: br_f3 = 3'b111;
         default:  br_ok = 1'b0;
      endcase

      raw = 32'h0;
      bad = 1'b0;
      case (cls_e)
         CLS_OPIMM: begin
            if (!f3m[3]) begin
               bad = 1'b1;
            end else if (is_shift) begin
               bad = (imm[31:5] != 27'h0);
               raw = {f7, imm[4:0], rs1, f3m[2:0], rd, OPC_OPIMM};
            end else begin
               bad = !fits_signed(imm, 12);
               raw = {imm[11:0], rs1, f3m[2:0], rd, OPC_OPIMM};
            end
         end
         CLS_OP: begin
            if (alu_op == ALU_SUB)
               raw = {F7_ALT, rs2, rs1, 3'b000, rd, OPC_OP};
            else if (f3m[3])
               raw = {f7, rs2, rs1, f3m[2:0], rd, OPC_OP};
            else
               bad = 1'b1;
         end
         CLS_LUI: begin
            bad = (alu_op != ALU_LUI) || (imm[11:0] != 12'h0);
            raw = {imm[31:12], rd, OPC_LUI};
         end
         CLS_AUIPC: begin
            bad = (alu_op != ALU_ADD) || (imm[11:0] != 12'h0);
            raw = {imm[31:12], rd, OPC_AUIPC};
         end
         CLS_JAL: begin
            bad = (alu_op != ALU_JUMP) || !fits_signed(imm, 21) || imm[0];
            raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         end
         CLS_JALR: begin
            bad = (alu_op != ALU_JUMP) || !fits_signed(imm, 12);
            raw = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
         end
         CLS_BRANCH: begin
            bad = !br_ok || !fits_signed(imm, 13) || imm[0];
            raw = {imm[12], imm[10:5], rs2, rs1, br_f3, imm[4:1], imm[11], OPC_BRANCH};
         end
`ifdef INSTR_ENCODER_LOADSTORE_EN
         CLS_LOAD: begin
            bad = !fits_signed(imm, 12) || (data_size == 3'b011) ||
                  (data_size == 3'b110) || (data_size == 3'b111);
            raw = {imm[11:0], rs1, data_size, rd, OPC_LOAD};
         end
         CLS_STORE: begin
            bad = !fits_signed(imm, 12) || (data_size[2] || (data_size[1:0] == 2'b11));
            raw = {imm[11:5], rs2, rs1, data_size, imm[4:0], OPC_STORE};
         end
`endif
         default: bad = 1'b1;
      endcase

      illegal = bad;
      word    = bad ? NOP_INSTR : raw;
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with output register, skid buffer and counters.
// Optional LOAD/STORE support via INSTR_ENCODER_LOADSTORE_EN (handled in instr_field_pack).
module instr_encoder
   import riscv_pkg::*;
#(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_class,
   input  logic [3:0]       in_alu_op,
   input  logic [2:0]       in_data_size,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count,
   input  logic             cnt_clr
);

   logic [31:0]      pack_word;
   logic             pack_ill;

   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic             out_err_q, out_err_d;
   logic             skid_valid_q, skid_valid_d;
   logic [31:0]      skid_instr_q, skid_instr_d;
   logic             skid_err_q, skid_err_d;
   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             accept;
   logic             out_free;

   instr_field_pack #(.NOP_INSTR(NOP_INSTR)) u_pack (
      .cls       (in_class),
      .alu_op    (in_alu_op),
      .data_size (in_data_size),
      .rs1       (in_rs1),
      .rs2       (in_rs2),
      .rd        (in_rd),
      .imm       (in_imm),
      .word      (pack_word),
      .illegal   (pack_ill)
   );

   assign in_ready  = !skid_valid_q;
   assign accept    = in_valid && !skid_valid_q;
   assign out_free  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign enc_count = enc_count_q;
   assign err_count = err_count_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_err_d   = skid_err_q;
      enc_count_d  = enc_count_q;
      err_count_d  = err_count_q;

      // Skid has priority into the output register; no accept can coincide with it.
      if (out_free) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_word;
            out_err_d   = pack_ill;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_instr_d = pack_word;
         skid_err_d   = pack_ill;
      end

      if (cnt_clr) begin
         enc_count_d = '0;
         err_count_d = '0;
      end else if (accept) begin
         enc_count_d = enc_count_q + 1'b1;
         if (pack_ill && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= 32'h0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= 32'h0;
         skid_err_q   <= 1'b0;
         enc_count_q  <= '0;
         err_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_err_q   <= skid_err_d;
         enc_count_q  <= enc_count_d;
         err_count_q  <= err_count_d;
      end
   end

endmodule
